// File: rtl/slave_port_arbiter_if.sv
// slave_port_arbiter_if: shared widths and the cross_bar_if request/response bundle.
package cross_bar_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
endpackage

interface cross_bar_if;
  import cross_bar_pkg::*;
  logic                  _req;
  logic                  _ack;
  logic [ADDR_WIDTH-1:0] _addr;
  logic                  _cmd;
  logic [DATA_WIDTH-1:0] _wdata;
  logic [DATA_WIDTH-1:0] _rdata;
  modport master (output _req, _addr, _cmd, _wdata, input _ack, _rdata);
  modport slave (input _req, _addr, _cmd, _wdata, output _ack, _rdata);
endinterface

// File: rtl/slave_port_arbiter.sv
// slave_port_arbiter: round-robin arbiter of NUM_MASTERS requesters onto one shared slave port.
// Optional watchdog compiled in with SLAVE_PORT_ARBITER_TIMEOUT_EN.
module slave_port_arbiter
  import cross_bar_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic         _clk,
  input logic         _rst_n,
  cross_bar_if.slave  m_if [NUM_MASTERS],
  cross_bar_if.master s_if
);
  localparam int PW = $clog2(NUM_MASTERS);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t                state, state_nx;
  logic [PW-1:0]         grant, grant_nx, ptr, ptr_nx, win, grant_inc;
  logic                  req_v   [NUM_MASTERS];
  logic                  cmd_v   [NUM_MASTERS];
  logic [ADDR_WIDTH-1:0] addr_v  [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] wdata_v [NUM_MASTERS];
  logic                  any_req, busy, tmo, ack_eff, done;
  logic [DATA_WIDTH-1:0] rdata_eff;

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("slave_port_arbiter: NUM_MASTERS must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_m
    assign req_v[i]       = m_if[i]._req;
    assign cmd_v[i]       = m_if[i]._cmd;
    assign addr_v[i]      = m_if[i]._addr;
    assign wdata_v[i]     = m_if[i]._wdata;
    assign m_if[i]._ack   = busy && grant == PW'(i) && ack_eff;
    assign m_if[i]._rdata = rdata_eff;
  end

  assign busy      = state == BUSY;
  assign ack_eff   = s_if._ack || tmo;
  assign done      = busy && ack_eff;
  assign rdata_eff = tmo ? DATA_WIDTH'(32'hDEAD_BEEF) : s_if._rdata;
  assign grant_inc = grant == PW'(NUM_MASTERS - 1) ? '0 : grant + 1'b1;

  // Scan from the farthest offset down so the nearest requester at or after ptr wins.
  always_comb begin
    int j;
    j       = 0;
    win     = ptr;
    any_req = 1'b0;
    for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_MASTERS) j -= NUM_MASTERS;
      if (req_v[j]) begin
        win     = PW'(j);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx     = busy ? ((done || !req_v[grant]) ? IDLE : BUSY) : (any_req ? BUSY : IDLE);
    grant_nx     = (!busy && any_req) ? win : grant;
    ptr_nx       = done ? grant_inc : ptr;
    s_if._req    = busy && req_v[grant] && !tmo;
    s_if._addr   = busy ? addr_v[grant] : '0;
    s_if._cmd    = busy && cmd_v[grant];
    s_if._wdata  = busy ? wdata_v[grant] : '0;
  end

  always_ff @(posedge _clk or negedge _rst_n) begin
    if (!_rst_n) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      ptr   <= ptr_nx;
    end
  end

`ifdef SLAVE_PORT_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt;
  // A genuine slave ack in the expiry cycle takes precedence over the fake response.
  assign tmo = busy && !s_if._ack && wd_cnt == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge _clk or negedge _rst_n) begin
    if (!_rst_n) wd_cnt <= '0;
    else wd_cnt <= (busy && !done) ? wd_cnt + 1'b1 : '0;
  end
`else
  assign tmo = 1'b0;
`endif
endmodule

// File: tb/tb_slave_port_arbiter.sv
// tb_slave_port_arbiter: directed stimulus with a scoreboard of expected master acks.
module tb_slave_port_arbiter;
  import cross_bar_pkg::*;
  localparam int N = 4;
  localparam logic [31:0] K = 32'hA5A5_A5B5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req   [N];
  logic        cmd   [N];
  logic [31:0] addr  [N];
  logic [31:0] wdata [N];
  logic        m_ack   [N];
  logic [31:0] m_rdata [N];
  logic        s_ack = 1'b0;
  logic [31:0] s_rdata = '0;
  logic        s_req, s_cmd;
  logic [31:0] s_addr, s_wdata;
  logic        s_en = 1'b0;
  int          lat = 0;
  int          ack_seen = 0;
  int          passed = 0;
  int          total = 0;

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic        cmd;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  cross_bar_if m_if [N] ();
  cross_bar_if s_if ();

  for (genvar g = 0; g < N; g++) begin : g_m
    assign m_if[g]._req   = req[g];
    assign m_if[g]._cmd   = cmd[g];
    assign m_if[g]._addr  = addr[g];
    assign m_if[g]._wdata = wdata[g];
    assign m_ack[g]       = m_if[g]._ack;
    assign m_rdata[g]     = m_if[g]._rdata;
  end
  assign s_if._ack   = s_ack;
  assign s_if._rdata = s_rdata;
  assign s_req       = s_if._req;
  assign s_cmd       = s_if._cmd;
  assign s_addr      = s_if._addr;
  assign s_wdata     = s_if._wdata;

  slave_port_arbiter #(.NUM_MASTERS(N), .TIMEOUT_CYCLES(8)) dut (
    ._clk  (clk),
    ._rst_n(rst_n),
    .m_if  (m_if),
    .s_if  (s_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic bad(input string name);
    total++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  function automatic exp_t mk(input int m, input logic [31:0] rd);
    mk = '{m, addr[m], cmd[m], wdata[m], rd};
  endfunction

  task automatic wait_acks(input int n);
    int c;
    c = 0;
    do begin
      @(posedge clk);
      c++;
    end while (ack_seen < n && c < 300);
    #1;
    if (ack_seen < n) bad("wait_acks");
  endtask

  task automatic wait_sreq();
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!s_req && c < 50);
    if (!s_req) bad("wait_sreq");
  endtask

  // Slave model: acks lat cycles after it first sees s_req, rdata = addr ^ K.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      s_ack = 1'b0;
      if (s_en && s_req) begin
        if (cnt >= lat) begin
          s_ack   = 1'b1;
          s_rdata = s_addr ^ K;
          cnt     = 0;
        end else cnt++;
      end else cnt = 0;
    end
  end

  always @(negedge clk) if (rst_n) begin : mon
    automatic int n = 0;
    automatic int idx = 0;
    exp_t e;
    for (int i = 0; i < N; i++) if (m_ack[i]) begin
      n++;
      idx = i;
    end
    if (n != 0) begin
      ack_seen++;
      chk("ack_onehot", n, 1);
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_ack: got ack on master %0d expected none", idx);
      end else begin
        e = exp_q.pop_front();
        chk("grant_master", idx, e.m);
        chk("rdata", m_rdata[idx], e.rdata);
        chk("s_addr", s_addr, e.addr);
        chk("s_cmd", 32'(s_cmd), 32'(e.cmd));
        chk("s_wdata", s_wdata, e.wdata);
`ifndef SLAVE_PORT_ARBITER_TIMEOUT_EN
        chk("ack_from_slave", 32'(s_ack), 1);
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    for (int i = 0; i < N; i++) begin
      req[i]   = 1'b0;
      cmd[i]   = (i == 3);
      wdata[i] = 32'hC0DE_0000 + 32'(i);
    end
    addr[0] = 32'h0000_0100;
    addr[1] = 32'h0000_0010;
    addr[2] = 32'h0000_0300;
    addr[3] = 32'h0000_0400;
    req[0]  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_req", 32'(s_req), 0);
    chk("rst_s_addr", s_addr, 0);
    chk("rst_s_wdata", s_wdata, 0);
    chk("rst_m0_ack", 32'(m_ack[0]), 0);
    // All four continuously requesting: 0,1,2,3,0,1.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    s_en  = 1'b1;
    lat   = 0;
    for (int i = 0; i < N; i++) req[i] = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(mk(i % N, addr[i % N] ^ K));
    wait_acks(ack_seen + 6);
    for (int i = 0; i < N; i++) req[i] = 1'b0;
    // Single read by master 1 at 0x10, slave responds two cycles later.
    lat    = 2;
    req[1] = 1'b1;
    exp_q.push_back(mk(1, 32'hA5A5_A5A5));
    wait_acks(ack_seen + 1);
    req[1] = 1'b0;
    // Master 0 alone leaves ptr at 1.
    lat    = 1;
    req[0] = 1'b1;
    exp_q.push_back(mk(0, addr[0] ^ K));
    wait_acks(ack_seen + 1);
    req[0] = 1'b0;
    // Masters 0 and 3 with ptr = 1: 3 then 0.
    req[0] = 1'b1;
    req[3] = 1'b1;
    exp_q.push_back(mk(3, addr[3] ^ K));
    exp_q.push_back(mk(0, addr[0] ^ K));
    wait_acks(ack_seen + 2);
    req[0] = 1'b0;
    req[3] = 1'b0;
    // Master 1 withdraws mid-transaction; ptr must stay at 1.
    s_en   = 1'b0;
    req[1] = 1'b1;
    wait_sreq();
    chk("drop_grant_addr", s_addr, addr[1]);
    @(posedge clk);
    #1;
    req[1] = 1'b0;
    @(negedge clk);
    chk("drop_s_req", 32'(s_req), 0);
    chk("drop_m1_ack", 32'(m_ack[1]), 0);
    @(posedge clk);
    #1;
    s_en   = 1'b1;
    lat    = 0;
    req[0] = 1'b1;
    req[1] = 1'b1;
    exp_q.push_back(mk(1, addr[1] ^ K));
    exp_q.push_back(mk(0, addr[0] ^ K));
    wait_acks(ack_seen + 2);
    req[0] = 1'b0;
    req[1] = 1'b0;
    // Reset while master 2 is granted; afterwards the search restarts at 0.
    s_en   = 1'b0;
    req[2] = 1'b1;
    wait_sreq();
    chk("rbusy_grant_addr", s_addr, addr[2]);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rbusy_s_req", 32'(s_req), 0);
    chk("rbusy_m2_ack", 32'(m_ack[2]), 0);
    chk("rbusy_s_addr", s_addr, 0);
    chk("rbusy_s_cmd", 32'(s_cmd), 0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    req[0] = 1'b1;
    s_en   = 1'b1;
    lat    = 0;
    exp_q.push_back(mk(0, addr[0] ^ K));
    exp_q.push_back(mk(2, addr[2] ^ K));
    wait_acks(ack_seen + 2);
    req[0] = 1'b0;
    req[2] = 1'b0;
    // Silent slave.
    s_en   = 1'b0;
    req[3] = 1'b1;
`ifdef SLAVE_PORT_ARBITER_TIMEOUT_EN
    exp_q.push_back(mk(3, 32'hDEAD_BEEF));
    wait_sreq();
    repeat (6) @(negedge clk);
    chk("wd_no_early_ack", 32'(m_ack[3]), 0);
    @(negedge clk);
    chk("wd_ack", 32'(m_ack[3]), 1);
    chk("wd_s_req", 32'(s_req), 0);
    @(posedge clk);
    #1;
    req[3] = 1'b0;
`else
    wait_sreq();
    base = ack_seen;
    repeat (120) @(negedge clk);
    chk("hold_s_req", 32'(s_req), 1);
    chk("hold_no_ack", ack_seen, base);
    exp_q.push_back(mk(3, addr[3] ^ K));
    @(posedge clk);
    #1;
    s_en = 1'b1;
    wait_acks(base + 1);
    req[3] = 1'b0;
`endif
    repeat (3) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/slave_port_arbiter.md
SLAVE_PORT_ARBITER -- requirements
Module: slave_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of requesting masters (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, watchdog limit in cycles (used only with the Configuration macro).
REQ-003 SHALL have port _clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port _rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port m_if, array [NUM_MASTERS] of cross_bar_if.slave modport: one request port per master.
REQ-006 SHALL have port s_if, cross_bar_if.master modport: the single shared downstream slave.
REQ-007 SHALL take all address and data widths from the package ADDR_WIDTH and DATA_WIDTH (32/32).

Function
REQ-008 SHALL implement an FSM with states IDLE and BUSY.
REQ-009 In IDLE, with any m_if[i]._req high, SHALL pick a winner by round-robin, starting the search at index ptr and wrapping modulo NUM_MASTERS.
REQ-010 SHALL register the winner index as grant and enter BUSY on the next edge; arbitration latency is one cycle.
REQ-011 In IDLE, s_if._req SHALL be 0 and every m_if[i]._ack SHALL be 0.
REQ-012 In BUSY, s_if._req/_addr/_cmd/_wdata SHALL be driven combinationally from m_if[grant].
REQ-013 In BUSY, s_if._ack SHALL be forwarded combinationally to m_if[grant]._ack only; all other masters see _ack = 0.
REQ-014 s_if._rdata SHALL be broadcast to all m_if[i]._rdata; only the granted master's _ack qualifies it.
REQ-015 On the edge where s_if._ack = 1 in BUSY, SHALL set ptr = (grant+1) mod NUM_MASTERS and return to IDLE.
REQ-016 Back-to-back: a master still requesting after its ack SHALL compete again in IDLE; at least one IDLE cycle between transactions.
REQ-017 If m_if[grant]._req drops in BUSY before ack (protocol violation), SHALL return to IDLE with ptr unchanged; s_if._req follows it low that cycle.
REQ-018 Grant SHALL NOT change while in BUSY regardless of other requests.
REQ-019 With a single requester, that requester SHALL always win regardless of ptr.
REQ-020 With all masters requesting continuously, every master SHALL be served exactly once per NUM_MASTERS transactions.

Reset
REQ-021 On _rst_n low, asynchronously: state = IDLE, grant = 0, ptr = 0, watchdog counter = 0.
REQ-022 During reset, s_if._req SHALL be 0 and all m_if[i]._ack SHALL be 0; _addr/_cmd/_wdata SHALL be 0.
REQ-023 Reset asserted in BUSY SHALL abort the transaction with no ack delivered to any master.

Configuration
REQ-024 Macro SLAVE_PORT_ARBITER_TIMEOUT_EN SHALL compile in a watchdog.
REQ-025 With the macro: counter clears on entering BUSY and increments each BUSY cycle without s_if._ack; on reaching TIMEOUT_CYCLES, SHALL pulse m_if[grant]._ack for one cycle with _rdata = 32'hDEAD_BEEF, drop s_if._req, and return to IDLE with ptr advanced as in REQ-015.
REQ-026 Without the macro: no counter exists; BUSY is held indefinitely until s_if._ack.

Verification
REQ-027 Reset mid-BUSY: master 2 granted, _rst_n low for 1 cycle -> no ack to master 2, s_if._req = 0, next grant starts search at 0.
REQ-028 Single request: m_if[1] read, addr 0x10, slave acks 2 cycles after s_if._req with rdata 0xA5A5A5A5 -> m_if[1]._ack = 1 same cycle, _rdata = 0xA5A5A5A5, others' _ack = 0.
REQ-029 All 4 masters request continuously, slave acks each in 1 cycle -> grant order 0,1,2,3,0,1; ptr wraps 3 -> 0.
REQ-030 Masters 0 and 3 request with ptr = 1 -> master 3 wins first, then master 0.
REQ-031 Master 1 drops _req in BUSY before ack -> FSM to IDLE, ptr stays 1, master 1 re-wins if it re-requests alone.
REQ-032 With SLAVE_PORT_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES = 8, slave never acks -> granted master gets _ack on BUSY cycle 8 with _rdata = 0xDEADBEEF; without the macro, BUSY persists beyond 100 cycles.
